// File: rtl/video_pkg.sv
// Shared video-path definitions: the default palette, RGB packing helpers
// and the palette write-handshake state type.
package video_pkg;

  localparam int MAX_CH_W  = 16;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } wr_state_e;

  // Reference palette at 3 bits per channel, packed {R, G, B}.
  localparam logic [8:0] DEFAULT_PAL3 [DEF_DEPTH] = '{
    9'b000000000, 9'b001111000, 9'b111111000, 9'b010001111,
    9'b110000010, 9'b111111111, 9'b001111100, 9'b111001111,
    9'b111100000, 9'b111110010, 9'b000010000, 9'b010000000,
    9'b000000000, 9'b000000000, 9'b000000000, 9'b000000000
  };

  // Stretch a 3-bit channel to ch_w bits by MSB-aligned bit replication.
  function automatic logic [MAX_CH_W-1:0] widen_chan(input logic [2:0] v, input int ch_w);
    logic [MAX_CH_W-1:0] res;
    res = '0;
    for (int i = 0; i < ch_w && i < MAX_CH_W; i++) begin
      res[ch_w-1-i] = v[2-(i%3)];
    end
    return res;
  endfunction

  // Pack three ch_w-bit channels into the low 3*ch_w bits as {R, G, B}.
  function automatic logic [3*MAX_CH_W-1:0] pack_rgb(input logic [MAX_CH_W-1:0] r,
                                                      input logic [MAX_CH_W-1:0] g,
                                                      input logic [MAX_CH_W-1:0] b,
                                                      input int ch_w);
    logic [3*MAX_CH_W-1:0] res;
    res = '0;
    for (int j = 0; j < ch_w && j < MAX_CH_W; j++) begin
      res[2*ch_w+j] = r[j];
      res[ch_w+j]   = g[j];
      res[j]        = b[j];
    end
    return res;
  endfunction

  // Default palette entry for any channel width; entries past the table are black.
  function automatic logic [3*MAX_CH_W-1:0] default_rgb(input int idx, input int ch_w);
    logic [8:0] base;
    if (idx >= DEF_DEPTH) return '0;
    base = DEFAULT_PAL3[idx];
    return pack_rgb(widen_chan(base[8:6], ch_w), widen_chan(base[5:3], ch_w),
                    widen_chan(base[2:0], ch_w), ch_w);
  endfunction

endpackage

// File: rtl/palette_colour_mux_if.sv
// Pixel-source, palette-update and RGB signals of the colour mux.
interface palette_colour_mux_if #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = 4,
  parameter int CH_W    = 3
);
  logic                     PixEn;
  logic [NUM_SRC*IDX_W-1:0] Colour;
  logic [NUM_SRC-2:0]       Sel;
  logic                     Blank;
  logic                     PalWrReq;
  logic [IDX_W-1:0]         PalAddr;
  logic [3*CH_W-1:0]        PalData;
  logic                     PalBusy;
  logic                     PalAck;
  logic [3*CH_W-1:0]        RGB;

  modport master (
    output PixEn, Colour, Sel, Blank, PalWrReq, PalAddr, PalData,
    input  PalBusy, PalAck, RGB
  );

  modport slave (
    input  PixEn, Colour, Sel, Blank, PalWrReq, PalAddr, PalData,
    output PalBusy, PalAck, RGB
  );
endinterface

// File: rtl/palette_ram.sv
// Palette register file: async read, sync write, reloads the default table on reset.
module palette_ram
  import video_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CH_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [3*CH_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [3*CH_W-1:0] rdata
);

  localparam int DEPTH = 2**IDX_W;

  logic [3*CH_W-1:0] mem_q [DEPTH];

  // Entry storage; reset restores the default palette.
  // NOTE: this array is reset on purpose (the palette must come back to its
  // default table), so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (3*CH_W)'(default_rgb(i, CH_W));
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read sees the pre-edge contents (read-before-write).
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/palette_colour_mux.sv
// Priority colour-source select, two-stage palette lookup to registered RGB,
// and a palette write handshake that defers the commit to blank time.
module palette_colour_mux
  import video_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = 4,
  parameter int CH_W    = 3
) (
  input  logic                  Clk,
  input  logic                  nReset,
  palette_colour_mux_if.slave   bus
);

  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic              blank_d, blank_q;
  logic [3*CH_W-1:0] rgb_d, rgb_q;
  logic [3*CH_W-1:0] rd_data;
  wr_state_e         state_d, state_q;
  logic [IDX_W-1:0]  pend_addr_d, pend_addr_q;
  logic [3*CH_W-1:0] pend_data_d, pend_data_q;
  logic              ack_d, ack_q;
  logic              wr_en;

  // Lowest set select wins; the last source is the fallback.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_idx = bus.Colour[(NUM_SRC-1)*IDX_W +: IDX_W];
    for (int k = NUM_SRC-2; k >= 0; k--) begin
      if (bus.Sel[k]) sel_idx = bus.Colour[k*IDX_W +: IDX_W];
    end
  end

  // Pipeline next state: both stages advance only on enabled pixel edges.
  always_comb begin
    idx_d   = idx_q;
    blank_d = blank_q;
    rgb_d   = rgb_q;
    if (bus.PixEn) begin
      idx_d   = sel_idx;
      blank_d = bus.Blank;
      rgb_d   = blank_q ? '0 : rd_data;
    end
  end

  // Write handshake: latch one request, commit it on the first blank edge.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ack_d       = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.PalWrReq) begin
          pend_addr_d = bus.PalAddr;
          pend_data_d = bus.PalData;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (bus.Blank) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers for the pixel pipeline and write handshake.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      idx_q       <= '0;
      blank_q     <= 1'b1;
      rgb_q       <= '0;
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      ack_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      ack_q       <= ack_d;
    end
  end

  palette_ram #(
    .IDX_W (IDX_W),
    .CH_W  (CH_W)
  ) u_palette_ram (
    .clk   (Clk),
    .rst_n (nReset),
    .we    (wr_en),
    .waddr (pend_addr_q),
    .wdata (pend_data_q),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  assign bus.RGB     = rgb_q;
  assign bus.PalBusy = (state_q == PEND);
  assign bus.PalAck  = ack_q;

endmodule

// File: tb/tb_palette_colour_mux.sv
// Scoreboard bench for palette_colour_mux: directed scenarios plus random
// traffic, checked against a behavioural model of the palette display path.
module tb_palette_colour_mux;

  localparam int NUM_SRC = 3;
  localparam int IDX_W   = 4;
  localparam int CH_W    = 3;

  typedef struct {
    logic [8:0] rgb;
    logic       busy;
    logic       ack;
  } exp_t;

  logic Clk;
  logic nReset;

  palette_colour_mux_if #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W), .CH_W(CH_W)) bus ();

  palette_colour_mux #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W), .CH_W(CH_W)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Behavioural model state.
  logic [8:0] m_pal [16];
  logic [3:0] m_idx;
  logic       m_blank;
  logic [8:0] m_rgb;
  logic       m_pending;
  logic [3:0] m_addr;
  logic [8:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pal = '{9'b000000000, 9'b001111000, 9'b111111000, 9'b010001111,
              9'b110000010, 9'b111111111, 9'b001111100, 9'b111001111,
              9'b111100000, 9'b111110010, 9'b000010000, 9'b010000000,
              9'b000000000, 9'b000000000, 9'b000000000, 9'b000000000};
    m_idx     = '0;
    m_blank   = 1'b1;
    m_rgb     = '0;
    m_pending = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, queue them after the edge.
  task automatic step(input logic pix, input logic [1:0] sel, input logic [11:0] colour,
                      input logic blank, input logic req, input logic [3:0] addr,
                      input logic [8:0] data);
    exp_t e;
    int   win;
    bit   found;
    bus.PixEn    = pix;
    bus.Sel      = sel;
    bus.Colour   = colour;
    bus.Blank    = blank;
    bus.PalWrReq = req;
    bus.PalAddr  = addr;
    bus.PalData  = data;
    win   = NUM_SRC - 1;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC - 1; k++) begin
      if (!found && sel[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
    e.rgb = m_rgb;
    if (pix) begin
      e.rgb   = m_blank ? 9'd0 : m_pal[m_idx];
      m_idx   = colour[win*IDX_W +: IDX_W];
      m_blank = blank;
      m_rgb   = e.rgb;
    end
    e.ack = 1'b0;
    if (m_pending) begin
      if (blank) begin
        m_pal[m_addr] = m_data;
        e.ack         = 1'b1;
        m_pending     = 1'b0;
      end
    end else if (req) begin
      m_pending = 1'b1;
      m_addr    = addr;
      m_data    = data;
    end
    e.busy = m_pending;
    @(posedge Clk);
    #1;
    exp_q.push_back(e);
  endtask

  // Show index idx from the default source (no selects), no write request.
  task automatic show(input logic [3:0] idx, input logic blank);
    step(1'b1, 2'b00, {idx, 8'h00}, blank, 1'b0, 4'd0, 9'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #1;
    nReset       = 1'b0;
    bus.PixEn    = 1'b0;
    bus.PalWrReq = 1'b0;
    #2;
    check("reset_rgb", 32'(bus.RGB), 32'd0);
    check("reset_busy", 32'(bus.PalBusy), 32'd0);
    check("reset_ack", 32'(bus.PalAck), 32'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge Clk) begin
    if (nReset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rgb", 32'(bus.RGB), 32'(e.rgb));
      check("busy", 32'(bus.PalBusy), 32'(e.busy));
      check("ack", 32'(bus.PalAck), 32'(e.ack));
    end
  end

  initial begin
    nReset       = 1'b0;
    bus.PixEn    = 1'b0;
    bus.Sel      = '0;
    bus.Colour   = '0;
    bus.Blank    = 1'b0;
    bus.PalWrReq = 1'b0;
    bus.PalAddr  = '0;
    bus.PalData  = '0;
    model_reset();
    #2;
    check("por_rgb", 32'(bus.RGB), 32'd0);
    check("por_busy", 32'(bus.PalBusy), 32'd0);
    @(posedge Clk);
    #1;
    nReset = 1'b1;

    // Default source, index 5 -> white after two edges.
    repeat (3) show(4'd5, 1'b0);
    // Mid-frame reset, then the same pattern again.
    show(4'd7, 1'b0);
    do_reset();
    repeat (3) show(4'd5, 1'b0);

    // Priority: source 0 beats source 1; source 1 alone; fallback source 2.
    repeat (2) step(1'b1, 2'b11, {4'd9, 4'd2, 4'd1}, 1'b0, 1'b0, 4'd0, 9'd0);
    repeat (2) step(1'b1, 2'b10, {4'd9, 4'd2, 4'd1}, 1'b0, 1'b0, 4'd0, 9'd0);
    repeat (3) step(1'b1, 2'b00, {4'd11, 4'd2, 4'd1}, 1'b0, 1'b0, 4'd0, 9'd0);

    // PixEn gating while the index changes 3 -> 8.
    repeat (2) show(4'd3, 1'b0);
    step(1'b1, 2'b00, {4'd8, 8'h00}, 1'b0, 1'b0, 4'd0, 9'd0);
    step(1'b0, 2'b00, {4'd8, 8'h00}, 1'b0, 1'b0, 4'd0, 9'd0);
    step(1'b0, 2'b00, {4'd8, 8'h00}, 1'b0, 1'b0, 4'd0, 9'd0);
    repeat (2) show(4'd8, 1'b0);

    // Deferred write to entry 3, committed when blank arrives.
    step(1'b1, 2'b00, {4'd3, 8'h00}, 1'b0, 1'b1, 4'd3, 9'b000000111);
    repeat (3) show(4'd3, 1'b0);
    repeat (2) show(4'd3, 1'b1);
    repeat (3) show(4'd3, 1'b0);

    // Second request while pending is dropped; entry 4 keeps its value.
    step(1'b1, 2'b00, {4'd4, 8'h00}, 1'b0, 1'b1, 4'd6, 9'b101010101);
    step(1'b1, 2'b00, {4'd4, 8'h00}, 1'b0, 1'b1, 4'd4, 9'b000000001);
    repeat (2) show(4'd4, 1'b1);
    repeat (3) show(4'd4, 1'b0);
    repeat (3) show(4'd6, 1'b0);

    // Request with blank already high commits on the following edge.
    step(1'b1, 2'b00, {4'd2, 8'h00}, 1'b1, 1'b1, 4'd2, 9'b100100100);
    repeat (2) show(4'd2, 1'b1);
    repeat (3) show(4'd2, 1'b0);

    // Reset during a pending write: no ack, entry 3 back to default.
    step(1'b1, 2'b00, {4'd3, 8'h00}, 1'b0, 1'b1, 4'd3, 9'b111000111);
    show(4'd3, 1'b0);
    do_reset();
    repeat (4) show(4'd3, 1'b0);

    // Blanking with index 5.
    repeat (3) show(4'd5, 1'b1);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 5) != 0, 2'($urandom), 12'($urandom), ($urandom % 4) == 0,
           ($urandom % 6) == 0, 4'($urandom), 9'($urandom));
    end

    @(negedge Clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
